fuzz_seq_ctrl: RTL
==================

FUZZ_SEQ_CTRL -- requirements
Module: fuzz_seq_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 68, width of the concatenated DUT stimulus {wire4, wire3, wire2, wire1, wire0}.
REQ-002 SHALL have parameter OUT_W, default 82, width of the DUT result y.
REQ-003 SHALL have parameter LAT, default 1, the number of clk cycles between stimulus launch and result sample (range 1..15).
REQ-004 SHALL have parameter SEED, default 68'h1, the LFSR start value (nonzero).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, a one-cycle request to run a test sequence.
REQ-008 SHALL have port num_vec, input, 8 bits, the vector count, sampled on accepted start.
REQ-009 SHALL have port stim, output, IN_W bits, the stimulus driven to both DUT copies.
REQ-010 SHALL have port y_ref, input, OUT_W bits, the result of the golden RTL DUT.
REQ-011 SHALL have port y_syn, input, OUT_W bits, the result of the synthesized-netlist DUT.
REQ-012 SHALL have port busy, output, 1 bit, high while a sequence runs.
REQ-013 SHALL have port done, output, 1 bit, a one-cycle pulse at sequence end.
REQ-014 SHALL have port pass, output, 1 bit, high when the last sequence had zero mismatches.
REQ-015 SHALL have port mismatch_cnt, output, 8 bits, the saturating mismatch count.
REQ-016 SHALL have port first_fail_idx, output, 8 bits, the index of the first mismatching vector.
REQ-017 SHALL have port first_fail_vld, output, 1 bit, high when first_fail_idx is valid.

Function
REQ-018 FSM states SHALL be IDLE, APPLY, WAIT, CHECK, DONE.
REQ-019 In IDLE, start=1 with num_vec>0 SHALL: latch num_vec, clear idx/mismatch_cnt/first_fail_vld, load LFSR with SEED, enter APPLY next cycle.
REQ-020 In IDLE, start=1 with num_vec=0 SHALL enter DONE directly, giving pass=1 and mismatch_cnt=0.
REQ-021 start SHALL be ignored in any state other than IDLE.
REQ-022 In APPLY, stim SHALL be all-zero for idx=0 and the current LFSR state for idx>=1; stim SHALL be registered and held stable until the next APPLY.
REQ-023 APPLY SHALL go to WAIT; WAIT SHALL last exactly LAT cycles, then go to CHECK.
REQ-024 In CHECK, if y_ref != y_syn (bitwise, any X/Z treated as mismatch by the bench), mismatch_cnt SHALL increment, saturating at 255, and on the first mismatch first_fail_idx SHALL be set to idx and first_fail_vld SHALL be set to 1.
REQ-025 From CHECK: if idx == latched num_vec-1, go to DONE; else idx SHALL increment, the LFSR SHALL advance if idx>=1, and the FSM SHALL go to APPLY.
REQ-026 LFSR SHALL be 68-bit Fibonacci, taps 68 and 59, shift-left with feedback into bit 0, advancing once per vector; when IN_W != 68 stim SHALL take the LSBs or zero-extend.
REQ-027 Per-vector period SHALL be LAT+2 cycles; total sequence length SHALL be num_vec*(LAT+2)+1 cycles from start to done.
REQ-028 DONE SHALL assert done for one cycle, set pass = (mismatch_cnt==0), and return to IDLE.
REQ-029 busy SHALL be 1 in APPLY, WAIT, CHECK and DONE, and 0 in IDLE.
REQ-030 pass, mismatch_cnt, first_fail_idx and first_fail_vld SHALL hold until the next accepted start.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, first_fail_vld=0, idx=0, LFSR=SEED.
REQ-032 Reset mid-sequence SHALL abort the run with no done pulse; the first start after rst_n release SHALL be accepted normally.

Structure
REQ-033 Package fuzz_pkg SHALL hold: the FSM state enum, the LFSR tap constants, and the IN_W/OUT_W defaults.
REQ-034 The LFSR SHALL be sub-module fuzz_lfsr (ports: clk, rst_n, load, adv, q); the FSM, comparator and counters SHALL live in fuzz_seq_ctrl.

Verification
REQ-035 num_vec=21, LAT=1, y_syn wired to y_ref -> done exactly 64 cycles after start, pass=1, mismatch_cnt=0, first_fail_vld=0.
REQ-036 Force y_syn bit 0 inverted only when idx=5 and idx=9 -> mismatch_cnt=2, first_fail_idx=5, first_fail_vld=1, pass=0.
REQ-037 Constant y_syn != y_ref, num_vec=255 -> mismatch_cnt=255 (saturation not exceeded), first_fail_idx=0.
REQ-038 num_vec=0 -> done pulse one cycle after start, pass=1, busy high for exactly 1 cycle.
REQ-039 rst_n low at vector 3 of 10 -> all outputs 0, no done pulse; restart runs 10 vectors with stim sequence identical to a clean run (vector 0 = 0, vector 1 = SEED).
REQ-040 start pulsed while busy -> ignored; num_vec changed mid-run -> vector count unaffected.

Source files
------------

// File: rtl/fuzz_pkg.sv
// Shared definitions for the fuzz sequencer: FSM encoding, LFSR geometry and
// default stimulus/result widths.
package fuzz_pkg;

    localparam int LFSR_W    = 68;
    localparam int TAP_HI    = 67;   // tap 68 (1-based)
    localparam int TAP_LO    = 58;   // tap 59 (1-based)

    localparam int IN_W_DEF  = 68;
    localparam int OUT_W_DEF = 82;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fuzz_lfsr.sv
// 68-bit Fibonacci LFSR, shift-left with feedback into bit 0; reloadable to SEED.
module fuzz_lfsr
    import fuzz_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 68'h1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;
    logic              w_fb;

    assign w_fb = r_q[TAP_HI] ^ r_q[TAP_LO];
    assign q    = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (adv) begin
            r_q <= {r_q[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/fuzz_seq_ctrl.sv
// Equivalence-fuzz sequencer: drives LFSR stimulus into a golden and a
// synthesized DUT copy, compares their results and records mismatches.
//
// state | meaning
// IDLE  | waiting for start
// APPLY | register stimulus for current vector
// WAIT  | LAT cycles for both DUT copies to settle
// CHECK | compare y_ref/y_syn, step to next vector
// DONE  | one-cycle done pulse, results published
module fuzz_seq_ctrl
    import fuzz_pkg::*;
#(
    parameter int                IN_W  = IN_W_DEF,
    parameter int                OUT_W = OUT_W_DEF,
    parameter int                LAT   = 1,
    parameter logic [LFSR_W-1:0] SEED  = 68'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       num_vec,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] y_ref,
    input  logic [OUT_W-1:0] y_syn,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       mismatch_cnt,
    output logic [7:0]       first_fail_idx,
    output logic             first_fail_vld
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_num;
    logic [7:0]        r_idx;
    logic [7:0]        r_mis_cnt;
    logic [7:0]        r_ff_idx;
    logic              r_ff_vld;
    logic              r_pass;
    logic [3:0]        r_wait;
    logic [IN_W-1:0]   r_stim;

    logic [LFSR_W-1:0] w_lfsr_q;
    logic [IN_W-1:0]   w_lfsr_fit;
    logic              w_lfsr_load;
    logic              w_lfsr_adv;
    logic              w_mis;
    logic              w_last;
    logic              w_wait_tc;
    logic [7:0]        w_cnt_nxt;

    fuzz_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_lfsr_load),
        .adv   (w_lfsr_adv),
        .q     (w_lfsr_q)
    );

    generate
        if (IN_W > LFSR_W) begin : g_zext
            assign w_lfsr_fit = {{(IN_W-LFSR_W){1'b0}}, w_lfsr_q};
        end else begin : g_trunc
            assign w_lfsr_fit = w_lfsr_q[IN_W-1:0];
        end
    endgenerate

    assign w_mis     = (y_ref != y_syn);
    assign w_last    = (r_idx == r_num - 8'd1);
    assign w_wait_tc = (r_wait == 4'd0);
    assign w_cnt_nxt = (w_mis && (r_mis_cnt != 8'hFF)) ? r_mis_cnt + 8'd1 : r_mis_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_load = 1'b0;
        w_lfsr_adv  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_lfsr_load = (num_vec != 8'd0);
                    w_state_nxt = (num_vec == 8'd0) ? DONE : APPLY;
                end
            end
            APPLY: w_state_nxt = WAIT;
            WAIT: begin
                if (w_wait_tc) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    // vector 0 is all-zero, so the seed itself is vector 1
                    w_lfsr_adv  = (r_idx != 8'd0);
                    w_state_nxt = APPLY;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num     <= 8'd0;
            r_idx     <= 8'd0;
            r_mis_cnt <= 8'd0;
            r_ff_idx  <= 8'd0;
            r_ff_vld  <= 1'b0;
            r_pass    <= 1'b0;
            r_wait    <= 4'd0;
            r_stim    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num     <= num_vec;
                        r_idx     <= 8'd0;
                        r_mis_cnt <= 8'd0;
                        r_ff_vld  <= 1'b0;
                        r_pass    <= (num_vec == 8'd0);
                    end
                end
                APPLY: begin
                    r_stim <= (r_idx == 8'd0) ? '0 : w_lfsr_fit;
                    r_wait <= 4'(LAT - 1);
                end
                WAIT: begin
                    if (!w_wait_tc) begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                CHECK: begin
                    r_mis_cnt <= w_cnt_nxt;
                    if (w_mis && !r_ff_vld) begin
                        r_ff_idx <= r_idx;
                        r_ff_vld <= 1'b1;
                    end
                    if (w_last) begin
                        r_pass <= (w_cnt_nxt == 8'd0);
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim           = r_stim;
    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign pass           = r_pass;
    assign mismatch_cnt   = r_mis_cnt;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_vld = r_ff_vld;

endmodule
